// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS-subset control path.
package mc_pkg;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StRExec  = 4'd6,
        StRWb    = 4'd7,
        StBranch = 4'd8,
        StAddiEx = 4'd9,
        StSltiEx = 4'd10,
        StIwbAdd = 4'd11,
        StIwbSlt = 4'd12,
        StJump   = 4'd13
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_funct_decoder.sv
// R-type funct field to ALU operation; unsupported functs fall back to ADD with valid low.
module alu_funct_decoder
    import mc_pkg::*;
#(
    parameter int unsigned OPW = 6
) (
    input  logic [OPW-1:0] funct,
    output logic [2:0]     operation,
    output logic           valid
);

    always_comb begin
        operation = ALU_ADD;
        valid     = 1'b1;
        case (funct)
            FN_ADD:  operation = ALU_ADD;
            FN_SUB:  operation = ALU_SUB;
            FN_AND:  operation = ALU_AND;
            FN_OR:   operation = ALU_OR;
            FN_SLT:  operation = ALU_SLT;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_alu_controller.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback and drives the ALU op.
module mc_alu_controller
    import mc_pkg::*;
#(
    parameter int unsigned OPW  = 6,
    parameter int unsigned ALUW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OPW-1:0]  opcode,
    input  logic [OPW-1:0]  funct,
    input  logic            zero,
    input  logic            mem_ready,
    output logic [ALUW-1:0] operation,
    output logic            pc_write,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      pc_src,
    output logic            illegal
);

    state_e     state_q, state_d;
    logic [2:0] fn_op;
    logic       fn_valid;

    alu_funct_decoder #(
        .OPW(OPW)
    ) u_funct_dec (
        .funct    (funct),
        .operation(fn_op),
        .valid    (fn_valid)
    );

    always_comb begin
        state_d    = state_q;
        operation  = '0;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        pc_src     = PCSRC_ALU;
        illegal    = 1'b0;
        case (state_q)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                operation = ALU_ADD;
                // Load strobes are masked while reset is held so nothing commits mid-reset.
                ir_write  = mem_ready & rst_n;
                pc_write  = mem_ready & rst_n;
                if (mem_ready) state_d = StDecode;
            end
            StDecode: begin
                alu_src_b = SRCB_IMM_SH;
                operation = ALU_ADD;
                case (opcode)
                    OP_RTYPE:     state_d = StRExec;
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_BEQ:       state_d = StBranch;
                    OP_ADDI:      state_d = StAddiEx;
                    OP_SLTI:      state_d = StSltiEx;
                    OP_J:         state_d = StJump;
                    default: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                operation = ALU_ADD;
                if (opcode == OP_LW)      state_d = StMemRd;
                else if (opcode == OP_SW) state_d = StMemWr;
                else                      state_d = StFetch;
            end
            StMemRd: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready) state_d = StMemWb;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready) state_d = StFetch;
            end
            StRExec: begin
                alu_src_a = 1'b1;
                operation = fn_op;
                illegal   = ~fn_valid;
                state_d   = fn_valid ? StRWb : StFetch;
            end
            StRWb: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                operation = fn_op;
                state_d   = StFetch;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                operation = ALU_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_write  = zero;
                state_d   = StFetch;
            end
            StAddiEx, StSltiEx: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                operation = (state_q == StSltiEx) ? ALU_SLT : ALU_ADD;
                state_d   = (state_q == StSltiEx) ? StIwbSlt : StIwbAdd;
            end
            StIwbAdd, StIwbSlt: begin
                // ALU inputs held from EX so the writeback value stays stable.
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                operation = (state_q == StIwbSlt) ? ALU_SLT : ALU_ADD;
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StJump: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
                state_d  = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StFetch;
        else        state_q <= state_d;
    end

endmodule

// File: doc/mc_alu_controller.md
Name: mc_alu_controller

Overview:
- Multicycle control FSM for the MIPS-subset datapath; it is the initiator side of the ALU operation interface.
- Decodes opcode/funct from the instruction register, sequences fetch/decode/execute/memory/writeback, and drives the 3-bit ALU operation code each cycle.
- Consumes the ALU zero flag for beq.
- Stalls on a memory ready handshake.

Parameters:
- OPW, 6, opcode/funct field width
- ALUW, 3, ALU operation code width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instr[31:26] from IR
- funct  in  6  instr[5:0] from IR
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completed current access this cycle
- operation  out  3  ALU op: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- pc_write  out  1  PC load enable (includes beq-taken)
- iord  out  1  0 = PC address, 1 = ALUOut address
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load enable
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- illegal  out  1  one-cycle pulse on unsupported opcode/funct

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n); state is forced to FETCH immediately.
- Output decode: all outputs are combinational decode of state, plus zero/mem_ready/opcode/funct where noted. Any output not listed as asserted in a state is 0 in that state.
- Outputs during reset: operation=010, alu_src_b=01, mem_read=1; all other outputs 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, operation=010, pc_src=00.
  - ir_write and pc_write equal mem_ready.
  - mem_ready=1 -> DECODE; otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, operation=010 (branch target into ALUOut). Next state by opcode:
  - 000000 -> REXEC
  - 100011, 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 001010 -> SLTIEX
  - 000010 -> JUMP
  - other -> FETCH with illegal=1
- MEMADR: alu_src_a=1, alu_src_b=10, operation=010. lw -> MEMRD; sw -> MEMWR.
- MEMRD: mem_read=1, iord=1. mem_ready -> MEMWB; otherwise hold.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEMWR: mem_write=1, iord=1. mem_ready -> FETCH; otherwise hold. mem_write stays high while holding.
- REXEC: alu_src_a=1, alu_src_b=00. Funct map:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - Unsupported funct: operation=010, illegal=1, next FETCH with no writeback.
  - Otherwise -> RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0; operation holds the funct decode -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, operation=110, pc_src=01, pc_write=zero (Mealy) -> FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=10, operation=010 -> IWB.
- SLTIEX: same as ADDIEX but operation=111 -> IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
  - IWB must keep the ALU inputs and operation of the preceding EX state, so the FSM records addi vs slti (separate IWB_ADD / IWB_SLT states are acceptable).
- JUMP: pc_src=10, pc_write=1 -> FETCH.
- CPI: R-type 4, addi/slti 4, beq 3, j 3, sw 4, lw 5 (each with zero wait cycles). Each mem_ready=0 cycle adds one cycle.
- Read/write exclusivity: mem_read and mem_write are never both 1.
- Single-write rule: reg_write and pc_write are never both 1, except pc_write in FETCH together with no reg_write.
- Reset mid-operation: any in-flight access is abandoned; no write strobe is asserted after rst_n falls.
- Undefined state encodings -> FETCH.

Decomposition:
- Shared package mc_pkg:
  - state enum
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI, OP_J
  - funct constants
  - ALU op constants: ALU_AND=000, ALU_OR=001, ALU_ADD=010, ALU_SUB=110, ALU_SLT=111
  - alu_src_b and pc_src encodings
- One natural sub-module: alu_funct_decoder (combinational funct -> operation + valid), reused in REXEC and RWB.

Test Plan:
- Reset with rst_n=0 mid-MEMWR -> mem_write drops immediately, state FETCH, mem_read=1, operation=010.
- lw (opcode 100011), mem_ready always 1 -> 5 cycles; reg_write=1 with mem_to_reg=1 only in cycle 5; iord=1 in cycle 4.
- R-type funct 100010 -> operation=110 in REXEC and RWB; reg_dst=1, reg_write=1 in cycle 4; funct 101010 -> operation=111.
- beq with zero=1 -> pc_write=1, pc_src=01, operation=110 in cycle 3; repeat with zero=0 -> pc_write=0.
- FETCH with mem_ready held 0 for 3 cycles -> ir_write/pc_write stay 0, DECODE entered on cycle 4; sw with mem_ready low for 2 cycles -> mem_write high 3 cycles.
- opcode 111111 -> illegal pulse in DECODE, no reg_write/mem_write, next FETCH; R-type funct 000111 -> illegal in REXEC, no reg_write.
